credit_link_tx: RTL
===================

Name: credit_link_tx

Overview:
- Output-side link transmitter for a router port.
- Pops flits from the port's local FIFO (registered-output FIFO: data valid the cycle after the read strobe) and drives them onto the inter-router link.
- Uses credit-based flow control sized to the downstream input FIFO depth, so the downstream buffer never overflows.
- Sits between an output FIFO and the physical link; its downstream peer is the neighbouring router's input FIFO.

Parameters:
- NUM_BITS, 8, flit width in bits.
- CREDITS, 8, downstream FIFO depth; initial and maximum credit count (power of 2 not required).
- CW, clog2(CREDITS)+1, credit counter width (derived localparam, not overridable).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- link_en  in  1  level; high permits new transfers.
- fifo_empty  in  1  local FIFO empty flag.
- fifo_data  in  NUM_BITS  local FIFO registered read data.
- fifo_rd_en  out  1  combinational read strobe to local FIFO.
- link_valid  out  1  registered; flit on link_data is valid this cycle.
- link_data  out  NUM_BITS  registered flit to downstream.
- credit_in  in  1  one-cycle pulse; downstream freed one slot.
- credit_count  out  CW  registered available credits.
- drained  out  1  registered; high in IDLE with no flit in flight.

Behaviour:
- Reset (async, rst_n low):
  - credit_count=CREDITS, link_valid=0, link_data=0, rd_pending=0, state=IDLE, drained=1.
  - Reset mid-transfer discards the in-flight flit.
- FSM states: IDLE, ACTIVE, DRAIN.
  - IDLE -> ACTIVE when link_en=1.
  - ACTIVE -> DRAIN when link_en=0.
  - DRAIN -> IDLE when rd_pending=0 and link_valid=0.
  - DRAIN -> ACTIVE when link_en=1 again.
- Read strobe:
  - fifo_rd_en = (state==ACTIVE) & link_en & !fifo_empty & (credit_count!=0).
  - No reads are issued in IDLE or DRAIN.
- Pipeline, with the read strobe issued in cycle N:
  - rd_pending=1 in cycle N+1, when fifo_data is valid.
  - In cycle N+2: link_valid=1 and link_data=fifo_data, captured at the end of N+1.
  - Latency from read strobe to link_valid is 2 cycles.
  - Sustained throughput is 1 flit/cycle while credits and data are available.
  - link_valid drops the cycle after the last pending flit is sent; link_data holds its last value.
- Credits:
  - A credit is consumed when fifo_rd_en is asserted (reservation), not when the flit reaches the link.
  - credit_in alone: +1.
  - fifo_rd_en alone: -1.
  - Both in the same cycle: count unchanged.
  - credit_count==0: fifo_rd_en held low; a credit_in that cycle allows a read the following cycle.
  - credit_in with credit_count==CREDITS and no read: count saturates at CREDITS (protocol error, see optional feature).
- Boundary: fifo_empty rising mid-burst stops reads immediately; flits already pending still complete.
- drained = (state==IDLE) & !rd_pending & !link_valid.

Optional Feature:
- CREDIT_CHECK_EN defined:
  - Adds output credit_err (1 bit, registered, reset 0).
  - credit_err is sticky; it is set on credit_in while credit_count==CREDITS and no read.
  - It clears only on reset.
  - A simulation-only $display reports the error time.
- CREDIT_CHECK_EN undefined: port absent; the overflow silently saturates.

Decomposition:
- Shared package noc_link_pkg:
  - clog2 function.
  - FSM state encoding constants: ST_IDLE=2'd0, ST_ACTIVE=2'd1, ST_DRAIN=2'd2.
  - Default NUM_BITS/CREDITS constants shared with the FIFO and the router top.
- One natural sub-module, credit_counter: up/down saturating counter with CW width, inc, dec, zero and max outputs.
- The FSM and output pipeline stay in credit_link_tx.

Test Plan:
- Reset then link_en=1, FIFO preloaded with 0x11,0x22,0x33, credit_in=0:
  - fifo_rd_en high 3 consecutive cycles.
  - link_valid high cycles 3-5 with data 0x11,0x22,0x33.
  - credit_count ends 5.
- CREDITS=8, FIFO holds 10 flits, no credit_in:
  - Exactly 8 flits sent; fifo_rd_en stays low; credit_count=0.
  - A single credit_in pulse yields exactly one more flit 2 cycles after the strobe.
- Sustained traffic with credit_in pulsed every cycle: credit_count stays constant; one flit per cycle on the link.
- link_en deasserted the cycle after a read strobe:
  - State enters DRAIN; the pending flit still appears on the link.
  - drained rises once link_valid falls; no further reads.
- rst_n pulled low while link_valid=1: all outputs return to reset values asynchronously; credit_count=8.
- CREDIT_CHECK_EN: credit_in with credit_count=8 and idle -> credit_err=1 next cycle, count stays 8, and credit_err stays 1 until reset.

Source files
------------

// File: rtl/noc_link_pkg.sv
// ---------------------------------------------------------------------------
// noc_link_pkg
//
// Shared definitions for the router link blocks (link transmitter, port FIFOs,
// router top):
//   - NOC_NUM_BITS / NOC_CREDITS : default flit width and downstream FIFO depth
//   - link_state_e               : link transmitter FSM encoding
//   - clog2()                    : ceiling log2 for deriving counter widths
// ---------------------------------------------------------------------------
package noc_link_pkg;

    localparam int NOC_NUM_BITS = 8;
    localparam int NOC_CREDITS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } link_state_e;

    // Smallest r with (1 << r) >= value; clog2(1) == 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage : noc_link_pkg

// File: rtl/credit_counter.sv
// ---------------------------------------------------------------------------
// credit_counter
//
// Up/down counter that saturates at both ends. Resets to MAX_VAL (all
// downstream slots free).
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   inc    in   add one (ignored when already at MAX_VAL unless dec is set)
//   dec    in   subtract one (ignored when already zero unless inc is set)
//   count  out  current value, CW bits
//   zero   out  count == 0
//   max    out  count == MAX_VAL
// ---------------------------------------------------------------------------
module credit_counter #(
    parameter int CW      = 4,
    parameter int MAX_VAL = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero,
    output logic          max
);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    assign zero  = (count_reg == '0);
    assign max   = (count_reg == CW'(MAX_VAL));
    assign count = count_reg;

    always_comb begin
        count_next = count_reg;
        case ({inc, dec})
            2'b10: if (!max)  count_next = count_reg + CW'(1);
            2'b01: if (!zero) count_next = count_reg - CW'(1);
            default: count_next = count_reg;   // idle, or return and reserve cancel out
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= CW'(MAX_VAL);
        end else begin
            count_reg <= count_next;
        end
    end

endmodule : credit_counter

// File: rtl/credit_link_tx.sv
// ---------------------------------------------------------------------------
// credit_link_tx
//
// Router output-port link transmitter. Pops flits from the local
// registered-output FIFO and drives them onto the inter-router link using
// credit-based flow control, so the neighbour's input FIFO (CREDITS deep)
// can never overflow. A credit is reserved when the read strobe fires; the
// flit reaches the link two cycles later.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset (drops in-flight flit)
//   link_en       in   level, permits new transfers
//   fifo_empty    in   local FIFO empty flag
//   fifo_data     in   local FIFO read data (valid the cycle after the strobe)
//   fifo_rd_en    out  combinational read strobe to the local FIFO
//   link_valid    out  registered, link_data carries a flit this cycle
//   link_data     out  registered flit (holds last value when idle)
//   credit_in     in   one-cycle pulse, downstream freed one slot
//   credit_count  out  registered available credits
//   drained       out  registered, IDLE with nothing in flight
//   credit_err    out  (CREDIT_CHECK_EN only) sticky credit-overflow flag
//
// Build option: define CREDIT_CHECK_EN to add the credit_err output. Without
// it, a credit returned while the counter is full is silently dropped.
// ---------------------------------------------------------------------------
module credit_link_tx
    import noc_link_pkg::*;
#(
    parameter int   NUM_BITS = NOC_NUM_BITS,
    parameter int   CREDITS  = NOC_CREDITS,
    localparam int  CW       = clog2(CREDITS) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                link_en,
    input  logic                fifo_empty,
    input  logic [NUM_BITS-1:0] fifo_data,
    output logic                fifo_rd_en,
    output logic                link_valid,
    output logic [NUM_BITS-1:0] link_data,
    input  logic                credit_in,
    output logic [CW-1:0]       credit_count,
    output logic                drained
`ifdef CREDIT_CHECK_EN
    ,
    output logic                credit_err
`endif
);

    link_state_e         state_reg;
    link_state_e         state_next;
    logic                rd_pending_reg;
    logic                link_valid_reg;
    logic [NUM_BITS-1:0] link_data_reg;
    logic                drained_reg;
    logic                drained_next;
    logic                cnt_zero;
    logic                cnt_max;
    logic                credit_ovf;

    // A returned credit with the counter already full and no reservation
    // in the same cycle has nowhere to go: it is a protocol error and is
    // dropped before reaching the counter.
    assign credit_ovf = credit_in & cnt_max & ~fifo_rd_en;

    credit_counter #(
        .CW      (CW),
        .MAX_VAL (CREDITS)
    ) u_credit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (credit_in & ~credit_ovf),
        .dec   (fifo_rd_en),
        .count (credit_count),
        .zero  (cnt_zero),
        .max   (cnt_max)
    );

    // Next-state and read strobe.
    always_comb begin
        state_next = state_reg;
        fifo_rd_en = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (link_en) state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                fifo_rd_en = link_en & ~fifo_empty & ~cnt_zero;
                if (!link_en) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (link_en) begin
                    state_next = ST_ACTIVE;
                end else if (!rd_pending_reg && !link_valid_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // drained is registered but must describe the same cycle as the other
    // registered outputs, so it is built from their next values.
    assign drained_next = (state_next == ST_IDLE) & ~fifo_rd_en & ~rd_pending_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            rd_pending_reg <= 1'b0;
            link_valid_reg <= 1'b0;
            link_data_reg  <= '0;
            drained_reg    <= 1'b1;
        end else begin
            state_reg      <= state_next;
            rd_pending_reg <= fifo_rd_en;
            link_valid_reg <= rd_pending_reg;
            if (rd_pending_reg) begin
                link_data_reg <= fifo_data;   // FIFO output is valid this cycle
            end
            drained_reg    <= drained_next;
        end
    end

    assign link_valid = link_valid_reg;
    assign link_data  = link_data_reg;
    assign drained    = drained_reg;

`ifdef CREDIT_CHECK_EN
    logic credit_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_err_reg <= 1'b0;
        end else if (credit_ovf) begin
            credit_err_reg <= 1'b1;
        end
    end

    assign credit_err = credit_err_reg;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && credit_ovf) begin
            $display("credit_link_tx: credit returned while counter full at time %0t", $time);
        end
    end
`endif
`endif

endmodule : credit_link_tx
